// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
// Two-requester round-robin arbiter in front of an SPI SRAM master sequencer.
// The system clock doubles as the SPI bit clock: the slave samples mosi on
// posedge clk and drives miso from the falling edge.
// Ports:
//   clk, rst                  system clock / synchronous active-high reset
//   r0_* (CPU), r1_* (loader) valid/ready request handshake, wr/addr/wdata
//                             request fields, done pulse and rdata result
//   cs_n, mosi, miso          SPI bus (chip select active low)
module spi_mem_arbiter #(
    parameter int         ADDR_W  = 24,
    parameter logic [7:0] CMD_RD  = 8'h03,
    parameter logic [7:0] CMD_WR  = 8'h02,
    parameter int         RD_TURN = 1,
    parameter int         CS_GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [7:0]        r0_wdata,
    output logic              r0_done,
    output logic [7:0]        r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [7:0]        r1_wdata,
    output logic              r1_done,
    output logic [7:0]        r1_rdata,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, TURN, DATA, GAP} state_t;

    localparam logic [7:0] TURN_LD = 8'(RD_TURN - 1);
    localparam logic [7:0] GAP_LD  = 8'(CS_GAP - 1);

    state_t state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        last;
    logic        ptr;           // 1: requester 1 preferred on contention
    logic        gnt_id;
    logic        g_wr;
    logic [39:0] sh, sh_nxt;    // {cmd, addr, wdata} shifted out MSB first
    logic [7:0]  rx, rx_nxt;
    logic        pick1, grant;
    logic        wr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [7:0]  wdata_sel;
    logic        cs_n_nxt, fin, r0_done_nxt, r1_done_nxt;

    assign last  = (cnt == '0);
    assign pick1 = r1_valid && (!r0_valid || ptr);
    assign r0_ready = (state == IDLE) && !rst && r0_valid && !pick1;
    assign r1_ready = (state == IDLE) && !rst && pick1;
    assign grant    = r0_ready || r1_ready;

    assign wr_sel    = pick1 ? r1_wr    : r0_wr;
    assign addr_sel  = pick1 ? r1_addr  : r0_addr;
    assign wdata_sel = pick1 ? r1_wdata : r0_wdata;

    // The shifter empties to zero by the end of every frame, so mosi is
    // zero whenever cs_n is high without any extra gating.
    assign mosi = sh[39];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; cnt holds (remaining clocks - 1) of the current phase
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - 8'd1;
        case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (grant) begin
                    state_nxt = CMD;
                    cnt_nxt   = 8'd7;
                end
            end
            CMD: if (last) begin
                state_nxt = ADDR;
                cnt_nxt   = 8'd23;
            end
            ADDR: if (last) begin
                if (!g_wr && RD_TURN > 0) begin
                    state_nxt = TURN;
                    cnt_nxt   = TURN_LD;
                end else begin
                    state_nxt = DATA;
                    cnt_nxt   = 8'd7;
                end
            end
            TURN: if (last) begin
                state_nxt = DATA;
                cnt_nxt   = 8'd7;
            end
            DATA: if (last) begin
                state_nxt = GAP;
                cnt_nxt   = GAP_LD;
            end
            GAP: if (last) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        cs_n_nxt = !(state_nxt inside {CMD, ADDR, TURN, DATA});
        sh_nxt   = {sh[38:0], 1'b0};
        if (grant)
            sh_nxt = {wr_sel ? CMD_WR : CMD_RD, 24'(addr_sel),
                      wr_sel ? wdata_sel : 8'h00};
        rx_nxt      = (state == DATA) ? {rx[6:0], miso} : rx;
        fin         = (state == DATA) && last;
        r0_done_nxt = fin && !gnt_id;
        r1_done_nxt = fin && gnt_id;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= 1'b0;
            gnt_id   <= 1'b0;
            g_wr     <= 1'b0;
            sh       <= '0;
            rx       <= '0;
            cs_n     <= 1'b1;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            sh      <= sh_nxt;
            rx      <= rx_nxt;
            cs_n    <= cs_n_nxt;
            r0_done <= r0_done_nxt;
            r1_done <= r1_done_nxt;
            if (grant) begin
                gnt_id <= pick1;
                g_wr   <= wr_sel;
                ptr    <= !pick1;
            end
            if (r0_done_nxt && !g_wr) r0_rdata <= rx_nxt;
            if (r1_done_nxt && !g_wr) r1_rdata <= rx_nxt;
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
module tb_spi_mem_arbiter;

    localparam int ADDR_W  = 24;
    localparam int RD_TURN = 1;
    localparam int CS_GAP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r0_valid = 1'b0, r0_wr = 1'b0, r0_done, r0_ready;
    logic r1_valid = 1'b0, r1_wr = 1'b0, r1_done, r1_ready;
    logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
    logic [7:0] r0_wdata = '0, r1_wdata = '0, r0_rdata, r1_rdata;
    logic cs_n, mosi;
    logic miso = 1'b0;

    spi_mem_arbiter #(
        .ADDR_W(ADDR_W), .CMD_RD(8'h03), .CMD_WR(8'h02),
        .RD_TURN(RD_TURN), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_wr(r0_wr),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_wr(r1_wr),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int unsigned vec = 0, errs = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memories: SPI slave and reference model ----------------
    logic [7:0] slv_mem [logic [23:0]];
    logic [7:0] ref_mem [logic [23:0]];

    function automatic logic [7:0] slv_rd(input logic [23:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 8'h00;
    endfunction
    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction
    task automatic preload(input logic [23:0] a, input logic [7:0] d);
        slv_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // SPI SRAM slave: samples mosi at posedge, drives miso from negedge
    int bc = 0;
    logic [7:0]  s_cmd = '0, s_dat = '0;
    logic [23:0] s_addr = '0;
    logic s_abort = 1'b0;

    always @(posedge clk) begin
        if (cs_n) begin
            if (bc != 0 && !s_abort) begin
                chk("spi_cmd_legal", 32'(s_cmd == 8'h02 || s_cmd == 8'h03), 1);
                chk("spi_frame_bits", bc, (s_cmd == 8'h02) ? 40 : 40 + RD_TURN);
            end
            bc = 0;
            s_abort = 1'b0;
        end else begin
            if (rst) s_abort = 1'b1;
            if (bc < 8) s_cmd = {s_cmd[6:0], mosi};
            else if (bc < 32) s_addr = {s_addr[22:0], mosi};
            else if (s_cmd == 8'h02 && bc < 40) s_dat = {s_dat[6:0], mosi};
            bc++;
            if (s_cmd == 8'h02 && bc == 40 && !s_abort) slv_mem[s_addr] = s_dat;
        end
    end

    always @(negedge clk) begin
        logic [7:0] b;
        int k;
        miso = 1'b0;
        if (!cs_n && s_cmd == 8'h03 && bc >= 32 + RD_TURN && bc < 40 + RD_TURN) begin
            b = slv_rd(s_addr);
            k = bc - 32 - RD_TURN;
            miso = b[7 - k];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [7:0]  rdata;
        int unsigned hs;
    } exp_t;
    exp_t q0[$], q1[$];
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    int glog[$];
    int unsigned hi_run = 100;

    task automatic sb_pop(input int id, input logic [7:0] rd);
        exp_t e;
        logic got = 1'b0;
        if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        if (!got) begin
            vec++; errs++;
            $display("FAIL done%0d_unexpected: got pulse, expected none (t=%0t)", id, $time);
            return;
        end
        chk($sformatf("latency%0d", id), cyc - e.hs, 41 + (e.wr ? 0 : RD_TURN));
        if (e.wr) chk($sformatf("rdata_hold%0d", id), rd, last_rd[id]);
        else begin
            chk($sformatf("rdata%0d", id), rd, e.rdata);
            last_rd[id] = e.rdata;
        end
    endtask

    // Monitor: bus invariants, grant log, completion checks
    always @(negedge clk) begin
        chk("mosi_idle_zero", 32'(cs_n & mosi), 0);
        chk("single_ready", 32'((r0_ready & r1_ready) | ((r0_ready | r1_ready) & ~cs_n)), 0);
        if (cs_n) hi_run++;
        else begin
            if (hi_run > 0) chk("cs_gap", 32'(hi_run >= CS_GAP), 1);
            hi_run = 0;
        end
        if (r0_ready) glog.push_back(0);
        if (r1_ready) glog.push_back(1);
        if (r0_done) sb_pop(0, r0_rdata);
        if (r1_done) sb_pop(1, r1_rdata);
    end

    // ---------------- stimulus ----------------
    task automatic req(input int id, input logic wr, input logic [23:0] a, input logic [7:0] d);
        exp_t e;
        logic got = 1'b0;
        @(posedge clk); #1;
        if (id == 0) begin r0_valid = 1'b1; r0_wr = wr; r0_addr = a; r0_wdata = d; end
        else         begin r1_valid = 1'b1; r1_wr = wr; r1_addr = a; r1_wdata = d; end
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if ((id == 0) ? r0_ready : r1_ready) got = 1'b1;
        end
        if (!got) begin
            vec++; errs++;
            $display("FAIL ready%0d_timeout: got no ready, expected ready within 400 cycles", id);
        end else begin
            // Reference model: accesses take effect in grant order
            e.wr = wr;
            e.hs = cyc;
            e.rdata = wr ? 8'h00 : ref_rd(a);
            if (wr) ref_mem[a] = d;
            if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk); #1;
        // Inputs are scrambled after acceptance; the DUT must have latched them
        if (id == 0) begin
            r0_valid = 1'b0; r0_wr = 1'($urandom); r0_addr = 24'($urandom); r0_wdata = 8'($urandom);
        end else begin
            r1_valid = 1'b0; r1_wr = 1'($urandom); r1_addr = 24'($urandom); r1_wdata = 8'($urandom);
        end
    endtask

    task automatic drain();
        logic empty = 1'b0;
        for (int n = 0; n < 400 && !empty; n++) begin
            if (q0.size() == 0 && q1.size() == 0) empty = 1'b1;
            else @(negedge clk);
        end
        if (!empty) begin
            vec++; errs++;
            $display("FAIL drain_timeout: got %0d/%0d outstanding, expected 0", q0.size(), q1.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        q0.delete(); q1.delete();
        @(posedge clk); #1 rst = 1'b0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with both valids high to show ready is held off
        r0_valid = 1'b1; r1_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_r1_ready", r1_ready, 0);
        chk("rst_done", {r0_done, r1_done}, 0);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0; rst = 1'b0;

        // Single write
        req(0, 1'b1, 24'h000200, 8'hA5);
        drain();
        chk("mem_0200", slv_rd(24'h000200), 8'hA5);

        // Single read with turnaround
        preload(24'h00FFFC, 8'h00);
        preload(24'h00FFFD, 8'h04);
        req(0, 1'b0, 24'h00FFFD, 8'h00);
        drain();
        chk("r0_rdata_fffd", r0_rdata, 8'h04);

        // Contention from reset: grants must alternate r0,r1,...
        pulse_reset();
        glog.delete();
        fork
            for (int i = 0; i < 4; i++) req(0, 1'b1, 24'h100 + 24'(i), 8'(8'hA0 + i));
            for (int i = 0; i < 4; i++) req(1, 1'b1, 24'h180 + 24'(i), 8'(8'hB0 + i));
        join
        drain();
        chk("grant_count", glog.size(), 8);
        for (int i = 0; i < glog.size() && i < 8; i++)
            chk($sformatf("grant_order%0d", i), glog[i], i % 2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mem_r0_%0d", i), slv_rd(24'h100 + 24'(i)), 8'(8'hA0 + i));
            chk($sformatf("mem_r1_%0d", i), slv_rd(24'h180 + 24'(i)), 8'(8'hB0 + i));
        end

        // Back-to-back r1 only
        for (int i = 0; i < 4; i++) req(1, 1'b1, 24'h10 + 24'(i), 8'((i + 1) * 17));
        drain();
        for (int i = 0; i < 4; i++)
            chk($sformatf("mem_b2b_%0d", i), slv_rd(24'h10 + 24'(i)), 8'((i + 1) * 17));

        // Reset in the middle of a write
        preload(24'h000300, 8'hEE);
        req(0, 1'b1, 24'h000300, 8'h77);
        repeat (19) @(posedge clk);
        pulse_reset();
        ref_mem[24'h000300] = 8'hEE;   // aborted write never lands
        @(negedge clk);
        chk("abort_cs_n", cs_n, 1);
        chk("abort_mosi", mosi, 0);
        repeat (60) @(negedge clk);
        chk("abort_mem_0300", slv_rd(24'h000300), 8'hEE);
        req(0, 1'b1, 24'h000300, 8'h99);
        drain();
        chk("mem_0300_after", slv_rd(24'h000300), 8'h99);

        // Read after write, r1 writes then r0 reads
        req(1, 1'b1, 24'h001234, 8'h5A);
        req(0, 1'b0, 24'h001234, 8'h00);
        drain();
        chk("raw_r0_rdata", r0_rdata, 8'h5A);

        // Randomised traffic from both requesters on a small shared window
        fork
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                req(0, 1'($urandom), 24'($urandom_range(0, 7)), 8'($urandom));
            end
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                req(1, 1'($urandom), 24'($urandom_range(0, 7)), 8'($urandom));
            end
        join
        drain();
        for (int a = 0; a < 8; a++)
            chk($sformatf("mem_final_%0d", a), slv_rd(24'(a)), ref_rd(24'(a)));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
